// File: rtl/clk_hp_monitor_if.sv
// rtl/clk_hp_monitor_if.sv - config write channel of the clock half-period monitor
interface clk_hp_monitor_if #(
  parameter int CNT_W = 8,
  parameter int IDX_W = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_idx;
  logic [CNT_W-1:0] cfg_hp;
  logic             cfg_rej;

  modport master (
    output cfg_valid,
    output cfg_idx,
    output cfg_hp,
    input  cfg_ready,
    input  cfg_rej
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idx,
    input  cfg_hp,
    output cfg_ready,
    output cfg_rej
  );
endinterface

// File: rtl/clk_hp_monitor.sv
// rtl/clk_hp_monitor.sv - per-lane half-period checker for generated clock lines
module clk_hp_monitor #(
  parameter int CLOCK_NUMBER = 9,
  parameter int CNT_W        = 8,
  parameter int IDX_W        = 4,
  parameter int LOCK_EDGES   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    freeze,
  input  logic [CLOCK_NUMBER-1:0] clk_in,
  clk_hp_monitor_if.slave         cfg,
  input  logic [CLOCK_NUMBER-1:0] err_clr,
  output logic [CLOCK_NUMBER-1:0] locked,
  output logic [CLOCK_NUMBER-1:0] err,
  output logic                    any_err,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [CNT_W-1:0]        meas_hp
);

  // Streak only has to reach LOCK_EDGES; it saturates there-or-above.
  localparam int               SW         = (LOCK_EDGES < 1) ? 1 : $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [SW-1:0]    STREAK_MAX = '1;
  localparam logic [SW-1:0]    LOCK_N     = SW'(LOCK_EDGES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } lane_state_t;

  logic [CLOCK_NUMBER-1:0] clk_q;
  lane_state_t             state      [CLOCK_NUMBER];
  logic [CNT_W-1:0]        hp         [CLOCK_NUMBER];
  logic [CNT_W-1:0]        cnt        [CLOCK_NUMBER];
  logic [CNT_W-1:0]        meas       [CLOCK_NUMBER];
  logic [SW-1:0]           streak     [CLOCK_NUMBER];

  logic                    cfg_acc;
  logic                    cfg_bad;
  logic [CLOCK_NUMBER-1:0] toggle;
  logic [CLOCK_NUMBER-1:0] wr_hit;
  logic [CLOCK_NUMBER-1:0] mis;
  logic [CLOCK_NUMBER-1:0] tout;
  logic [CNT_W-1:0]        interval   [CLOCK_NUMBER];
  logic [SW-1:0]           streak_inc [CLOCK_NUMBER];

  // Writes are always accepted outside reset; bad index or the reserved
  // all-ones half-period turns the accepted write into a reject.
  assign cfg.cfg_ready = ~rst_i;
  assign cfg_acc       = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_bad       = (32'(cfg.cfg_idx) >= CLOCK_NUMBER) || (cfg.cfg_hp == CNT_MAX);

  // Edges seen while frozen are swallowed: clk_q still follows clk_in.
  assign toggle = (clk_in ^ clk_q) & {CLOCK_NUMBER{~freeze}};

  // Per-lane decode of write hit, measured interval, mismatch and timeout.
  always_comb begin
    for (int n = 0; n < CLOCK_NUMBER; n++) begin
      wr_hit[n]     = cfg_acc && !cfg_bad && (cfg.cfg_idx == IDX_W'(n));
      interval[n]   = cnt[n] + CNT_W'(1);
      streak_inc[n] = (streak[n] == STREAK_MAX) ? streak[n] : streak[n] + SW'(1);
      mis[n]        = !wr_hit[n] && (state[n] == ST_TRACK) && toggle[n] &&
                      (interval[n] != hp[n]);
      tout[n]       = !wr_hit[n] && !freeze && (state[n] == ST_TRACK) && !toggle[n] &&
                      (cnt[n] == hp[n]);
    end
  end

  // Lane state machines, sticky errors, reject pulse and readback registers.
  always_ff @(posedge clk_i) begin
    clk_q <= clk_in;
    if (rst_i) begin
      cfg.cfg_rej <= 1'b0;
      locked      <= '0;
      err         <= '0;
      any_err     <= 1'b0;
      meas_hp     <= '0;
      for (int n = 0; n < CLOCK_NUMBER; n++) begin
        state[n]  <= ST_IDLE;
        hp[n]     <= '0;
        cnt[n]    <= '0;
        streak[n] <= '0;
        meas[n]   <= '0;
      end
    end else begin
      cfg.cfg_rej <= cfg_acc && cfg_bad;
      any_err     <= |err;
      meas_hp     <= (32'(rd_idx) < CLOCK_NUMBER) ? meas[rd_idx] : '0;
      for (int n = 0; n < CLOCK_NUMBER; n++) begin
        if (wr_hit[n]) begin
          // A config write restarts the lane regardless of what it saw this tick.
          hp[n]     <= cfg.cfg_hp;
          cnt[n]    <= '0;
          streak[n] <= '0;
          locked[n] <= 1'b0;
          err[n]    <= 1'b0;
          state[n]  <= (cfg.cfg_hp == '0) ? ST_IDLE : ST_ACQUIRE;
        end else begin
          // Error set beats a coincident clear.
          if (mis[n] || tout[n]) begin
            err[n] <= 1'b1;
          end else if (err_clr[n]) begin
            err[n] <= 1'b0;
          end
          if (!freeze) begin
            case (state[n])
              ST_ACQUIRE: begin
                // First edge only establishes phase; nothing to compare yet.
                if (toggle[n]) begin
                  cnt[n]   <= '0;
                  state[n] <= ST_TRACK;
                end
              end
              ST_TRACK: begin
                if (toggle[n]) begin
                  meas[n] <= interval[n];
                  cnt[n]  <= '0;
                  if (mis[n]) begin
                    locked[n] <= 1'b0;
                    streak[n] <= '0;
                  end else begin
                    streak[n] <= streak_inc[n];
                    if (streak_inc[n] >= LOCK_N) begin
                      locked[n] <= 1'b1;
                    end
                  end
                end else if (tout[n]) begin
                  // Clock went quiet: fall back and re-acquire phase.
                  locked[n] <= 1'b0;
                  streak[n] <= '0;
                  state[n]  <= ST_ACQUIRE;
                end else if (cnt[n] != CNT_MAX) begin
                  cnt[n] <= cnt[n] + CNT_W'(1);
                end
              end
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_hp_monitor.sv
// tb/tb_clk_hp_monitor.sv - directed bench for clk_hp_monitor
module tb_clk_hp_monitor;
  localparam int CN = 9;
  localparam int CW = 8;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          freeze;
  logic [CN-1:0] clk_in;
  logic [CN-1:0] err_clr;
  logic [CN-1:0] locked;
  logic [CN-1:0] err;
  logic          any_err;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] meas_hp;

  int n_cmp = 0;
  int n_bad = 0;

  clk_hp_monitor_if #(.CNT_W(CW), .IDX_W(IW)) cfg_bus ();

  clk_hp_monitor #(
    .CLOCK_NUMBER(CN),
    .CNT_W(CW),
    .IDX_W(IW),
    .LOCK_EDGES(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .freeze(freeze),
    .clk_in(clk_in),
    .cfg(cfg_bus),
    .err_clr(err_clr),
    .locked(locked),
    .err(err),
    .any_err(any_err),
    .rd_idx(rd_idx),
    .meas_hp(meas_hp)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int lane;
    int hp;
    int period;
    int n;
    bit exp_locked;
    bit exp_err;
    int exp_meas;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int hp);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx   = IW'(idx);
    cfg_bus.cfg_hp    = CW'(hp);
    step();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse(input int lane, input int gap);
    repeat (gap - 1) step();
    clk_in[lane] = ~clk_in[lane];
    step();
  endtask

  initial begin
    vecs[0] = '{lane: 0, hp: 3, period: 3, n: 3, exp_locked: 1, exp_err: 0, exp_meas: 3};
    vecs[1] = '{lane: 1, hp: 3, period: 3, n: 2, exp_locked: 0, exp_err: 0, exp_meas: 3};
    vecs[2] = '{lane: 2, hp: 4, period: 5, n: 3, exp_locked: 0, exp_err: 1, exp_meas: 5};
    vecs[3] = '{lane: 8, hp: 2, period: 2, n: 4, exp_locked: 1, exp_err: 0, exp_meas: 2};
    vecs[4] = '{lane: 3, hp: 0, period: 3, n: 4, exp_locked: 0, exp_err: 0, exp_meas: 0};
    vecs[5] = '{lane: 4, hp: 7, period: 6, n: 3, exp_locked: 0, exp_err: 1, exp_meas: 6};
    vecs[6] = '{lane: 5, hp: 1, period: 1, n: 3, exp_locked: 1, exp_err: 0, exp_meas: 1};
    vecs[7] = '{lane: 6, hp: 2, period: 3, n: 3, exp_locked: 0, exp_err: 1, exp_meas: 3};

    rst_i             = 1'b1;
    freeze            = 1'b0;
    clk_in            = '0;
    err_clr           = '0;
    rd_idx            = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idx   = '0;
    cfg_bus.cfg_hp    = '0;

    // Reset state
    step();
    step();
    check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_any_err", 32'(any_err), 32'd0);
    check("rst_meas", 32'(meas_hp), 32'd0);
    check("rst_rej", 32'(cfg_bus.cfg_rej), 32'd0);
    rst_i = 1'b0;
    #1;
    check("ready_after_rst", 32'(cfg_bus.cfg_ready), 32'd1);
    step();

    // Table: configure, drive n edges at a fixed period, check lane outputs
    for (int i = 0; i < 8; i++) begin
      rd_idx = IW'(vecs[i].lane);
      cfg_write(vecs[i].lane, vecs[i].hp);
      pulse(vecs[i].lane, 1);
      for (int k = 1; k < vecs[i].n; k++) pulse(vecs[i].lane, vecs[i].period);
      step();
      check($sformatf("vec%0d_locked", i), 32'(locked[vecs[i].lane]), 32'(vecs[i].exp_locked));
      check($sformatf("vec%0d_err", i), 32'(err[vecs[i].lane]), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_meas", i), 32'(meas_hp), 32'(vecs[i].exp_meas));
      cfg_write(vecs[i].lane, 0);
    end

    // Mismatch on a locked lane, then relock after two good intervals
    rd_idx = 4'd0;
    cfg_write(0, 4);
    pulse(0, 1);
    pulse(0, 4);
    pulse(0, 4);
    check("a_locked", 32'(locked[0]), 32'd1);
    pulse(0, 5);
    check("a_mis_err", 32'(err[0]), 32'd1);
    check("a_mis_unlock", 32'(locked[0]), 32'd0);
    pulse(0, 4);
    check("a_one_good", 32'(locked[0]), 32'd0);
    pulse(0, 4);
    check("a_relock", 32'(locked[0]), 32'd1);
    cfg_write(0, 0);

    // Timeout when edges stop, then a quiet re-acquire
    cfg_write(5, 5);
    pulse(5, 1);
    pulse(5, 5);
    pulse(5, 5);
    check("b_locked", 32'(locked[5]), 32'd1);
    repeat (5) step();
    check("b_no_err_yet", 32'(err[5]), 32'd0);
    step();
    check("b_tout_err", 32'(err[5]), 32'd1);
    check("b_tout_unlock", 32'(locked[5]), 32'd0);
    step();
    check("b_any_err", 32'(any_err), 32'd1);
    err_clr[5] = 1'b1;
    step();
    err_clr = '0;
    check("b_clr", 32'(err[5]), 32'd0);
    pulse(5, 3);
    check("b_reacq_no_err", 32'(err[5]), 32'd0);
    cfg_write(5, 0);

    // Freeze mid-interval
    rd_idx = 4'd6;
    cfg_write(6, 6);
    pulse(6, 1);
    pulse(6, 6);
    pulse(6, 6);
    check("c_locked", 32'(locked[6]), 32'd1);
    repeat (2) step();
    freeze = 1'b1;
    repeat (10) step();
    check("c_frozen_err", 32'(err[6]), 32'd0);
    check("c_frozen_lock", 32'(locked[6]), 32'd1);
    freeze = 1'b0;
    pulse(6, 4);
    check("c_resume_err", 32'(err[6]), 32'd0);
    check("c_resume_lock", 32'(locked[6]), 32'd1);
    step();
    check("c_meas", 32'(meas_hp), 32'd6);
    rd_idx = 4'd12;
    step();
    check("rd_out_of_range", 32'(meas_hp), 32'd0);
    cfg_write(6, 0);

    // Rejected writes and err_clr racing a mismatch
    rd_idx = 4'd7;
    cfg_write(7, 4);
    pulse(7, 1);
    pulse(7, 4);
    pulse(7, 4);
    check("d_locked", 32'(locked[7]), 32'd1);
    cfg_write(9, 5);
    check("d_rej_idx", 32'(cfg_bus.cfg_rej), 32'd1);
    check("d_rej_idx_lock", 32'(locked[7]), 32'd1);
    step();
    check("d_rej_pulse_end", 32'(cfg_bus.cfg_rej), 32'd0);
    cfg_write(7, 8'hFF);
    check("d_rej_hp", 32'(cfg_bus.cfg_rej), 32'd1);
    check("d_rej_hp_lock", 32'(locked[7]), 32'd1);
    pulse(7, 1);
    check("d_good_after_rej", 32'(err[7]), 32'd0);
    step();
    err_clr[7]  = 1'b1;
    clk_in[7]   = ~clk_in[7];
    step();
    err_clr     = '0;
    check("d_set_beats_clr", 32'(err[7]), 32'd1);
    check("d_mis_unlock", 32'(locked[7]), 32'd0);
    step();
    check("d_meas", 32'(meas_hp), 32'd2);
    err_clr[7] = 1'b1;
    step();
    err_clr    = '0;
    check("d_clr", 32'(err[7]), 32'd0);
    pulse(7, 1);
    check("d_reerr", 32'(err[7]), 32'd1);
    step();
    check("d_any_err", 32'(any_err), 32'd1);

    // Reset mid-operation overrides a write, a clear and a toggle
    rst_i             = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx   = 4'd9;
    cfg_bus.cfg_hp    = 8'd5;
    err_clr           = '1;
    clk_in[7]         = ~clk_in[7];
    #1;
    check("e_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
    step();
    check("e_locked", 32'(locked), 32'd0);
    check("e_err", 32'(err), 32'd0);
    check("e_any_err", 32'(any_err), 32'd0);
    check("e_meas", 32'(meas_hp), 32'd0);
    check("e_rej", 32'(cfg_bus.cfg_rej), 32'd0);
    rst_i             = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    err_clr           = '0;
    pulse(7, 2);
    pulse(7, 3);
    pulse(7, 2);
    step();
    check("e_idle_err", 32'(err), 32'd0);
    check("e_idle_locked", 32'(locked), 32'd0);
    check("e_idle_meas", 32'(meas_hp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_hp_monitor.md
CLK_HP_MONITOR -- requirements
Module: clk_hp_monitor

Interface
REQ-001 SHALL have parameter CLOCK_NUMBER, default 9, number of monitored clock lanes.
REQ-002 SHALL have parameter CNT_W, default 8, width of half-period values and interval counters.
REQ-003 SHALL have parameter IDX_W, default 4, width of lane index ports.
REQ-004 SHALL have parameter LOCK_EDGES, default 2, consecutive good intervals required for lock.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_i  input  1  base tick clock; all logic on posedge.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have port freeze  input  1  hold all lane counters and state.
REQ-009 SHALL have port clk_in  input  CLOCK_NUMBER  generated clock lines under monitor.
REQ-010 SHALL have port cfg_valid  input  1  config write request.
REQ-011 SHALL have port cfg_ready  output  1  config write can be accepted.
REQ-012 SHALL have port cfg_idx  input  IDX_W  lane being configured.
REQ-013 SHALL have port cfg_hp  input  CNT_W  expected half-period in ticks; 0 disables the lane.
REQ-014 SHALL have port cfg_rej  output  1  one-cycle pulse when an accepted write is rejected.
REQ-015 SHALL have port err_clr  input  CLOCK_NUMBER  per-lane clear of sticky error.
REQ-016 SHALL have port locked  output  CLOCK_NUMBER  per-lane lock status.
REQ-017 SHALL have port err  output  CLOCK_NUMBER  per-lane sticky error.
REQ-018 SHALL have port any_err  output  1  registered OR of all err bits.
REQ-019 SHALL have port rd_idx  input  IDX_W  lane selected for measurement readback.
REQ-020 SHALL have port meas_hp  output  CNT_W  last measured interval of lane rd_idx.

Function
REQ-021 SHALL register clk_in into clk_q every tick, including while frozen; toggle(n) = clk_in[n] != clk_q[n] and freeze==0.
REQ-022 SHALL keep per lane: hp register, counter cnt, streak counter, last measurement, and a state IDLE / ACQUIRE / TRACK.
REQ-023 SHALL assert cfg_ready=1 whenever rst_i=0; a write is accepted when cfg_valid and cfg_ready are both 1.
REQ-024 SHALL reject an accepted write when cfg_idx >= CLOCK_NUMBER or cfg_hp is all-ones: lane state unchanged, cfg_rej=1 the next cycle.
REQ-025 SHALL, on a non-rejected write, load hp, clear locked, err, streak and cnt; next state is IDLE if cfg_hp=0, otherwise ACQUIRE.
REQ-026 SHALL let a config write to a lane take priority over that lane's toggle or timeout in the same cycle.
REQ-027 SHALL, in IDLE, ignore toggles; locked=0 and err never sets.
REQ-028 SHALL, in ACQUIRE, on toggle set cnt=0 and go to TRACK, with no comparison.
REQ-029 SHALL, in TRACK, increment cnt each non-toggle tick, saturating at all-ones.
REQ-030 SHALL, on a toggle in TRACK, compute interval = cnt+1, store it as the last measurement, and set cnt=0.
REQ-031 SHALL, when interval == hp, increment streak (saturating) and set locked when streak reaches LOCK_EDGES.
REQ-032 SHALL, when interval != hp, set err, clear locked and streak, and remain in TRACK.
REQ-033 SHALL, in TRACK with no toggle and cnt == hp, flag timeout: set err, clear locked and streak, and go to ACQUIRE.
REQ-034 SHALL hold cnt, streak, state, locked and measurement while freeze=1; config writes and err_clr remain active.
REQ-035 SHALL clear err[n] when err_clr[n]=1, except that a same-cycle error set wins over clear.
REQ-036 SHALL present meas_hp as the rd_idx lane measurement with 1-cycle registered latency, and as 0 for rd_idx >= CLOCK_NUMBER.
REQ-037 SHALL update any_err one cycle after err changes.

Reset
REQ-038 SHALL, while rst_i=1 at posedge clk_i, drive cfg_ready=0, cfg_rej=0, locked=0, err=0, any_err=0, meas_hp=0.
REQ-039 SHALL, on reset, put all lanes in IDLE with hp=0, cnt=0, streak=0 and measurements 0, and load clk_q from clk_in.
REQ-040 SHALL let reset asserted mid-operation override every config write, toggle and err_clr in that cycle.

Verification
REQ-041 SHALL verify: lane0 hp=3, clk_in[0] toggles every 3 ticks -> locked[0]=1 after the 3rd toggle, err[0]=0, meas_hp=3.
REQ-042 SHALL verify: locked lane hp=4, one interval of 5 ticks -> err=1 and locked=0 at that toggle; relock after 2 good intervals.
REQ-043 SHALL verify: lane hp=5, toggles stop -> err=1 at tick 6 after the last toggle; state ACQUIRE; no error on the next toggle.
REQ-044 SHALL verify: freeze=1 for 10 ticks mid-interval on an hp=6 lane -> no error, and the interval resumes counting correctly.
REQ-045 SHALL verify: write cfg_idx=9 or cfg_hp=8'hFF -> cfg_rej pulse, no lane change; err_clr coincident with a mismatch -> err stays 1.
REQ-046 SHALL verify: rst_i asserted during TRACK with err=1 -> all outputs 0 next cycle, lanes IDLE.
